// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, state encoding and defaults for the fetch unit
package fetch_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;

   // Default halt opcode (IR[15:12]) and reset fetch address
   localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;
   localparam addr_t      RESET_PC_DEF    = 9'd0;

   // Fetch sequencer states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   // True when the opcode field of an instruction word matches the halt opcode
   function automatic logic is_halt(input word_t w, input logic [3:0] op);
      return w[DATA_W-1 -: 4] == op;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, memory and instruction signals of the fetch unit
interface fetch_unit_if;
   import fetch_pkg::*;

   logic  en;
   logic  stall;
   logic  br_taken;
   addr_t br_addr;
   word_t mem_out;
   addr_t mem_addr;
   logic  mem_r;
   logic  mem_w;
   logic  mem_e;
   word_t ir;
   addr_t pc;
   logic  valid;
   logic  halted;

   // Fetch unit side
   modport master (
      input  en, stall, br_taken, br_addr, mem_out,
      output mem_addr, mem_r, mem_w, mem_e, ir, pc, valid, halted
   );

   // Environment side: controller, RAM and instruction consumer
   modport slave (
      output en, stall, br_taken, br_addr, mem_out,
      input  mem_addr, mem_r, mem_w, mem_e, ir, pc, valid, halted
   );

endinterface

// File: rtl/fetch_unit_pc_inc_9.sv
// rtl/fetch_unit_pc_inc_9.sv - 9-bit fetch pointer incrementer, wraps 1FF to 000
module pc_inc_9
   import fetch_pkg::*;
(
   input  addr_t a,
   output addr_t y
);

   // Carry out of bit 8 is dropped so the pointer wraps modulo 512
   assign y = a + addr_t'(1);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer for a 512x16 combinational-read RAM
module fetch_unit
   import fetch_pkg::*;
#(
   parameter addr_t      RESET_PC    = RESET_PC_DEF,
   parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
)
(
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   logic [1:0] state;
   addr_t      fpc;
   addr_t      fpc_inc;
   word_t      ir_q;
   addr_t      pc_q;
   logic       valid_q;
   logic       halted_q;

   pc_inc_9 u_pc_inc (
      .a (fpc),
      .y (fpc_inc)
   );

   // RAM is addressed by the fetch pointer at all times; reads only while fetching
   assign bus.mem_addr = fpc;
   assign bus.mem_w    = 1'b0;
   assign bus.mem_r    = (state == ST_FETCH);
   assign bus.mem_e    = (state == ST_FETCH);
   assign bus.ir       = ir_q;
   assign bus.pc       = pc_q;
   assign bus.valid    = valid_q;
   assign bus.halted   = halted_q;

   // Sequencing: reset, run control, branch redirect, consumer stall hold, halt detect
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         fpc      <= RESET_PC;
         ir_q     <= '0;
         pc_q     <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               valid_q <= 1'b0;
               if (bus.br_taken) fpc <= bus.br_addr;
               if (bus.en) state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (!bus.en) begin
                  // Park; the unfetched address is kept unless a branch replaces it
                  state   <= ST_IDLE;
                  valid_q <= 1'b0;
                  if (bus.br_taken) fpc <= bus.br_addr;
               end else if (bus.br_taken) begin
                  // Branch beats stall; IR/PC keep the last delivered instruction
                  fpc     <= bus.br_addr;
                  valid_q <= 1'b0;
               end else if (!(bus.stall && valid_q)) begin
                  // A stall only matters when there is a live instruction to hold
                  ir_q    <= bus.mem_out;
                  pc_q    <= fpc;
                  valid_q <= 1'b1;
                  fpc     <= fpc_inc;
                  if (is_halt(bus.mem_out, HALT_OPCODE)) begin
                     state    <= ST_HALT;
                     halted_q <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
               // Halt instruction stays visible until consumed; only reset leaves
               if (!bus.stall) valid_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural reference model
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, en0, stall0, br0;
   logic [8:0]  br_addr0;
   logic        rst1, en1;
   logic [15:0] mem [0:511];

   int total = 0;
   int bad   = 0;

   // Reference model state: run flag, halt flag, fetch pointer and delivered instruction
   logic        m_run, m_halt, m_valid;
   logic [8:0]  m_fpc, m_pc;
   logic [15:0] m_ir;

   fetch_unit_if bus0 ();
   fetch_unit_if bus1 ();

   assign bus0.en       = en0;
   assign bus0.stall    = stall0;
   assign bus0.br_taken = br0;
   assign bus0.br_addr  = br_addr0;
   assign bus0.mem_out  = mem[bus0.mem_addr];

   assign bus1.en       = en1;
   assign bus1.stall    = 1'b0;
   assign bus1.br_taken = 1'b0;
   assign bus1.br_addr  = 9'h000;
   assign bus1.mem_out  = mem[bus1.mem_addr];

   fetch_unit dut0 (
      .clk (clk),
      .rst (rst0),
      .bus (bus0)
   );

   fetch_unit #(.RESET_PC(9'h1FE)) dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (bus1)
   );

   // Advance one clock; the model consumes the same inputs the DUT sees at the edge
   task automatic step();
      if (rst0) begin
         m_run = 0; m_halt = 0; m_valid = 0; m_fpc = 9'h000; m_pc = 9'h000; m_ir = 16'h0000;
      end else if (m_halt) begin
         if (!stall0) m_valid = 0;
      end else if (!m_run) begin
         if (br0) m_fpc = br_addr0;
         m_valid = 0;
         m_run   = en0;
      end else if (!en0) begin
         m_run   = 0;
         m_valid = 0;
         if (br0) m_fpc = br_addr0;
      end else if (br0) begin
         m_fpc   = br_addr0;
         m_valid = 0;
      end else if (!(stall0 && m_valid)) begin
         m_ir    = mem[m_fpc];
         m_pc    = m_fpc;
         m_valid = 1;
         m_fpc   = 9'((int'(m_fpc) + 1) % 512);
         m_halt  = (m_ir[15:12] == 4'hF);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 512; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
   endtask

   task automatic do_reset();
      rst0 = 1; en0 = 0; stall0 = 0; br0 = 0; br_addr0 = 9'h000;
      step();
      rst0 = 0;
   endtask

   task automatic test_reset();
      fill_mem();
      rst0 = 1; rst1 = 1; en0 = 1; en1 = 1; stall0 = 1'($urandom); br0 = 1; br_addr0 = 9'h155;
      step();
      step();
      total++;
      if ({bus0.ir, bus0.pc, bus0.valid, bus0.halted} !== 27'd0) begin
         bad++;
         $display("FAIL reset_outputs got ir=%h pc=%h valid=%b halted=%b want all zero",
                  bus0.ir, bus0.pc, bus0.valid, bus0.halted);
      end
      total++;
      if ({bus0.mem_addr, bus0.mem_r, bus0.mem_e, bus0.mem_w} !== 12'd0) begin
         bad++;
         $display("FAIL reset_mem got addr=%h r=%b e=%b w=%b want 000/0/0/0",
                  bus0.mem_addr, bus0.mem_r, bus0.mem_e, bus0.mem_w);
      end
      total++;
      if (bus1.mem_addr !== 9'h1FE || bus1.valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_pc_param got addr=%h valid=%b want 1fe/0", bus1.mem_addr, bus1.valid);
      end
      rst1 = 0; en1 = 0;
   endtask

   task automatic test_sequence();
      fill_mem();
      for (int i = 0; i < 4; i++) mem[i] = 16'(16'h1001 + i);
      do_reset();
      en0 = 1;
      step();
      total++;
      if (bus0.valid !== 1'b0 || bus0.mem_r !== 1'b1 || bus0.mem_e !== 1'b1 || bus0.mem_addr !== 9'h000) begin
         bad++;
         $display("FAIL seq_first_fetch got valid=%b r=%b e=%b addr=%h want 0/1/1/000",
                  bus0.valid, bus0.mem_r, bus0.mem_e, bus0.mem_addr);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (bus0.ir !== 16'(16'h1001 + i) || bus0.pc !== 9'(i) || bus0.valid !== 1'b1) begin
            bad++;
            $display("FAIL seq_word%0d got ir=%h pc=%h valid=%b want %h/%h/1",
                     i, bus0.ir, bus0.pc, bus0.valid, 16'(16'h1001 + i), 9'(i));
         end
      end
   endtask

   task automatic test_stall();
      fill_mem();
      for (int i = 0; i < 4; i++) mem[i] = 16'(16'h1001 + i);
      do_reset();
      en0 = 1;
      step(); step(); step();
      stall0 = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (bus0.ir !== 16'h1002 || bus0.pc !== 9'h001 || bus0.valid !== 1'b1 ||
             bus0.mem_r !== 1'b1 || bus0.mem_addr !== 9'h002) begin
            bad++;
            $display("FAIL stall_hold%0d got ir=%h pc=%h valid=%b r=%b addr=%h want 1002/001/1/1/002",
                     i, bus0.ir, bus0.pc, bus0.valid, bus0.mem_r, bus0.mem_addr);
         end
      end
      stall0 = 0;
      step();
      total++;
      if (bus0.ir !== 16'h1003 || bus0.pc !== 9'h002 || bus0.valid !== 1'b1) begin
         bad++;
         $display("FAIL stall_release got ir=%h pc=%h valid=%b want 1003/002/1", bus0.ir, bus0.pc, bus0.valid);
      end
   endtask

   task automatic test_branch();
      fill_mem();
      for (int i = 0; i < 4; i++) mem[i] = 16'(16'h1001 + i);
      do_reset();
      en0 = 1;
      step(); step(); step(); step();
      br0 = 1; br_addr0 = 9'h040; stall0 = 1;
      step();
      total++;
      if (bus0.valid !== 1'b0 || bus0.ir !== 16'h1003 || bus0.pc !== 9'h002 || bus0.mem_addr !== 9'h040) begin
         bad++;
         $display("FAIL branch_bubble got valid=%b ir=%h pc=%h addr=%h want 0/1003/002/040",
                  bus0.valid, bus0.ir, bus0.pc, bus0.mem_addr);
      end
      br0 = 0; stall0 = 0;
      step();
      total++;
      if (bus0.valid !== 1'b1 || bus0.ir !== mem[64] || bus0.pc !== 9'h040) begin
         bad++;
         $display("FAIL branch_target got valid=%b ir=%h pc=%h want 1/%h/040", bus0.valid, bus0.ir, bus0.pc, mem[64]);
      end
      br0 = 1; br_addr0 = 9'h1FF;
      step();
      br0 = 0; stall0 = 1;
      step();
      total++;
      if (bus0.valid !== 1'b1 || bus0.ir !== mem[511] || bus0.pc !== 9'h1FF) begin
         bad++;
         $display("FAIL stall_no_valid got valid=%b ir=%h pc=%h want 1/%h/1ff", bus0.valid, bus0.ir, bus0.pc, mem[511]);
      end
      stall0 = 0;
      step();
      total++;
      if (bus0.ir !== 16'h1001 || bus0.pc !== 9'h000 || bus0.mem_addr !== 9'h001) begin
         bad++;
         $display("FAIL branch_wrap got ir=%h pc=%h addr=%h want 1001/000/001", bus0.ir, bus0.pc, bus0.mem_addr);
      end
   endtask

   task automatic test_wrap();
      fill_mem();
      mem[510] = 16'h2000; mem[511] = 16'h2001; mem[0] = 16'h2002;
      rst1 = 1;
      step();
      rst1 = 0; en1 = 1;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (bus1.pc !== 9'(510 + i) || bus1.ir !== 16'(16'h2000 + i) || bus1.valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_pc%0d got pc=%h ir=%h valid=%b want %h/%h/1",
                     i, bus1.pc, bus1.ir, bus1.valid, 9'(510 + i), 16'(16'h2000 + i));
         end
      end
      en1 = 0;
   endtask

   task automatic test_halt();
      fill_mem();
      mem[5] = 16'hF000;
      do_reset();
      en0 = 1;
      for (int i = 0; i < 7; i++) step();
      total++;
      if (bus0.ir !== 16'hF000 || bus0.pc !== 9'h005 || bus0.valid !== 1'b1 ||
          bus0.halted !== 1'b1 || bus0.mem_r !== 1'b0) begin
         bad++;
         $display("FAIL halt_fetch got ir=%h pc=%h valid=%b halted=%b r=%b want f000/005/1/1/0",
                  bus0.ir, bus0.pc, bus0.valid, bus0.halted, bus0.mem_r);
      end
      br0 = 1; br_addr0 = 9'h0AA; en0 = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (bus0.valid !== 1'b0 || bus0.halted !== 1'b1 || bus0.ir !== 16'hF000 ||
             bus0.mem_addr !== 9'h006 || bus0.mem_r !== 1'b0 || bus0.mem_e !== 1'b0) begin
            bad++;
            $display("FAIL halt_hold%0d got valid=%b halted=%b ir=%h addr=%h r=%b e=%b want 0/1/f000/006/0/0",
                     i, bus0.valid, bus0.halted, bus0.ir, bus0.mem_addr, bus0.mem_r, bus0.mem_e);
         end
      end
      rst0 = 1;
      step();
      total++;
      if ({bus0.ir, bus0.pc, bus0.valid, bus0.halted, bus0.mem_addr, bus0.mem_r} !== 37'd0) begin
         bad++;
         $display("FAIL halt_reset got ir=%h pc=%h valid=%b halted=%b addr=%h r=%b want all zero",
                  bus0.ir, bus0.pc, bus0.valid, bus0.halted, bus0.mem_addr, bus0.mem_r);
      end
      rst0 = 0; br0 = 0;
      step();
      total++;
      if (bus0.valid !== 1'b0 || bus0.halted !== 1'b0) begin
         bad++;
         $display("FAIL halt_no_pulse got valid=%b halted=%b want 0/0", bus0.valid, bus0.halted);
      end
   endtask

   task automatic test_random();
      logic [38:0] got, want;
      for (int i = 0; i < 512; i++)
         mem[i] = ($urandom_range(0, 31) == 0) ? {4'hF, 12'($urandom)}
                                               : {4'($urandom_range(0, 14)), 12'($urandom)};
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst0     = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
         en0      = ($urandom_range(0, 7) != 0);
         stall0   = ($urandom_range(0, 3) == 0);
         br0      = ($urandom_range(0, 9) == 0);
         br_addr0 = 9'($urandom);
         step();
         want = {m_ir, m_pc, m_valid, m_halt, m_fpc, m_run && !m_halt, m_run && !m_halt, 1'b0};
         got  = {bus0.ir, bus0.pc, bus0.valid, bus0.halted, bus0.mem_addr, bus0.mem_r, bus0.mem_e, bus0.mem_w};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL random_cycle%0d got {ir,pc,v,h,addr,r,e,w}=%h want %h", c, got, want);
         end
      end
   endtask

   initial begin
      rst0 = 1; en0 = 0; stall0 = 0; br0 = 0; br_addr0 = 9'h000;
      rst1 = 1; en1 = 0;
      m_run = 0; m_halt = 0; m_valid = 0; m_fpc = 9'h000; m_pc = 9'h000; m_ir = 16'h0000;
      test_reset();
      test_sequence();
      test_stall();
      test_branch();
      test_wrap();
      test_halt();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: FETCH_UNIT

Interface
REQ-001 Parameter RESET_PC, default 9'd0: fetch address loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 4'hF: IR[15:12] value that stops fetching.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: synchronous, active-high reset.
REQ-005 EN  input  1: run enable; 0 parks the unit in IDLE.
REQ-006 STALL  input  1: consumer not ready; holds IR, PC and VALID.
REQ-007 BR_TAKEN  input  1: redirect fetch to BR_ADDR.
REQ-008 BR_ADDR  input  9: branch target word address.
REQ-009 MEM_OUT  input  16: read data from the 512x16 RAM; combinational with MEM_ADDR.
REQ-010 MEM_ADDR  output  9: RAM word address (= FPC).
REQ-011 MEM_R, MEM_W, MEM_E  output  1 each: RAM read, write and enable strobes.
REQ-012 IR  output  16: fetched instruction.
REQ-013 PC  output  9: address IR was fetched from.
REQ-014 VALID  output  1: IR/PC hold a live instruction.
REQ-015 HALTED  output  1: halt instruction fetched; unit stopped.

Function
REQ-016 States: IDLE, FETCH, HALT; internal 9-bit fetch pointer FPC.
REQ-017 MEM_W SHALL be constant 0; MEM_ADDR SHALL equal FPC at all times.
REQ-018 MEM_E and MEM_R SHALL be 1 only in FETCH.
REQ-019 IDLE: EN=1 -> FETCH next cycle; otherwise stay; VALID<=0.
REQ-020 FETCH, no STALL, no branch: IR<=MEM_OUT, PC<=FPC, VALID<=1, FPC<=FPC+1 at the edge.
REQ-021 Fetch latency: address presented in cycle N; IR/VALID visible in cycle N+1; one instruction per cycle sustained.
REQ-022 FPC increment SHALL wrap modulo 512 (9'h1FF -> 9'h000).
REQ-023 STALL=1 with VALID=1: IR, PC, VALID, FPC all hold; MEM_R stays 1.
REQ-024 STALL=1 with VALID=0: treated as no stall (fetch proceeds).
REQ-025 BR_TAKEN=1 in IDLE or FETCH: FPC<=BR_ADDR, VALID<=0, IR/PC hold; no redirect cycle latched; first target instruction VALID two cycles after the BR_TAKEN cycle.
REQ-026 BR_TAKEN and STALL simultaneous: branch wins.
REQ-027 EN=0 while in FETCH: next state IDLE, VALID<=0, FPC holds (unfetched address kept); a same-cycle BR_TAKEN still loads FPC.
REQ-028 Loading IR with IR[15:12]==HALT_OPCODE -> next state HALT, HALTED<=1, instruction delivered with VALID=1.
REQ-029 HALT: MEM_R=0; VALID drops to 0 on first edge with STALL=0; BR_TAKEN and EN ignored; exit only via RST.

Reset
REQ-030 RST=1 at an edge: state<=IDLE, FPC<=RESET_PC, IR<=16'h0000, PC<=9'h000, VALID<=0, HALTED<=0; overrides all other inputs.
REQ-031 RST mid-fetch or in HALT SHALL discard the in-flight instruction; no VALID pulse follows.

Structure
REQ-032 Shared package fetch_pkg SHALL hold state encoding, ADDR_W=9, DATA_W=16, default HALT_OPCODE.
REQ-033 One sub-module PC_INC_9 (9-bit incrementer, wrap on carry-out) SHALL implement FPC+1.

Verification
REQ-034 RAM words 0..3 = 16'h1001..16'h1004, EN=1 after reset -> IR sequence 1001,1002,1003,1004 on consecutive cycles, PC 0..3, VALID continuous.
REQ-035 STALL=1 for 3 cycles while IR=16'h1002 -> IR, PC=1, VALID held 3 cycles; next IR=16'h1003.
REQ-036 BR_TAKEN=1, BR_ADDR=9'h040 at PC=2 (STALL=1 same cycle) -> VALID 0 one cycle, then IR=mem[64], PC=9'h040.
REQ-037 RESET_PC=9'h1FE, mem[510]=16'h2000, mem[511]=16'h2001, mem[0]=16'h2002 -> PC 1FE,1FF,000 in order.
REQ-038 mem[5]=16'hF000 -> IR=16'hF000 VALID=1, HALTED=1, MEM_R=0 thereafter; BR_TAKEN ignored; RST returns to IDLE with all outputs at reset values.
